uart_byte_receiver: RTL and testbench
=====================================

# uart_byte_receiver

Serial-to-parallel UART receiver for 8N1 frames, LSB first. It is the receive-side counterpart of the baud-rate tick generator used on the transmit path. It sits between the board RX pin and the byte consumer, which is the image-pixel loader that feeds the neural network. It derives its own 16x oversampling tick from the system clock, re-samples each bit at mid-period, and presents each good byte with a one-cycle valid strobe.

## Interface
- `baudrate`, 32'd9600, serial bit rate in baud.
- `frequency`, 32'd100000000, `clk` frequency in Hz.
- `clk` input 1: system clock; all logic is on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `rx` input 1: asynchronous serial line; idles high.
- `data` output 8: last correctly received byte.
- `data_valid` output 1: one-`clk` pulse when `data` is updated.
- `framing_error` output 1: one-`clk` pulse when a stop bit is sampled low.
- `busy` output 1: high whenever the FSM is not in IDLE.

## Operation
- Reset values: `data`=8'h00, `data_valid`=0, `framing_error`=0, `busy`=0. FSM=IDLE, all counters 0, synchronizer flops=1.
- `rx` passes through a 2-flop synchronizer. All decisions use the synchronized value `rxs`.
- Oversample divisor D = frequency/(baudrate*16), integer division. D must be ≥2; this is a synthesis-time check.
- 32-bit divider counter runs 0..D-1. `stick` (one-cycle pulse) is asserted when the count equals D-1, and the counter then wraps to 0.
- The divider is cleared to 0 on the IDLE→START transition, so phase is aligned to the start edge. Otherwise it is free-running.
- Counters: `s` (4-bit sub-sample count), `n` (3-bit bit index), 8-bit shift register (shifted right, new bit enters at MSB).
- FSM states and transitions:
  - IDLE: `armed` is set when `rxs`=1. If `armed` and `rxs`=0 → START, with `s`=0 and divider cleared.
  - START: on each `stick`, `s`++. At `s`=7, if `rxs`=0 → DATA with `s`=0, `n`=0. If `rxs`=1 → IDLE (glitch rejected, no outputs).
  - DATA: on each `stick`, `s`++. At `s`=15, shift in `rxs`; if `n`=7 → STOP, else `n`++. `s` wraps to 0.
  - STOP: on each `stick`, `s`++. At `s`=15:
    - If `rxs`=1: `data`←shift register and `data_valid`=1 for one cycle.
    - If `rxs`=0: `framing_error`=1 for one cycle, `data` unchanged, and `armed` cleared.
    - Either way → IDLE.
- Break (line held low): after a framing error, `armed` stays clear until `rxs`=1 is seen. No repeated errors are reported during a break.
- `data_valid` and `framing_error` are never high in the same cycle.
- Reset asserted mid-frame returns everything to reset values immediately. A partial byte is discarded and never reported.

## Timing
- Input latency: 2 `clk` through the synchronizer.
- Sample points fall at 8, 24, 40 … 16·k+8 ticks after the start edge, i.e. bit centres, ±1 tick of phase error.
- The output pulse occurs at the mid-stop-bit sample: 9.5 bit periods (152 ticks) after the synchronized start edge, +1 `clk` for the registered output.
- Back-to-back frames: a new start bit may begin half a stop bit after the sample point. IDLE accepts it on the first `clk` after return.
- Tolerated baud mismatch: ±3%.

## Test plan
All tests use `frequency`=3200000, `baudrate`=100000: D=2, 32 `clk` per bit.
- Send 0xA5 with a valid stop bit → `data`=0xA5, a single `data_valid` pulse about 306 `clk` after the start edge, `framing_error` stays 0.
- Back-to-back 0x00 then 0xFF with no idle gap → two `data_valid` pulses, `data`=0x00 then 0xFF, no errors.
- Drive `rx` low for 8 `clk` (4 ticks), then high → no outputs, `busy` returns to 0 before tick 8.
- Send 0x3C with stop bit forced 0, then hold `rx` low for 2000 `clk`, then high, then send 0x81 → exactly one `framing_error` pulse, `data` stays at its previous value, then `data`=0x81 with `data_valid`.
- Pulse `rst_n` low for 1 `clk` during bit 4 of a frame → all outputs 0, no pulse for that frame, next frame 0x5A is received correctly.
- Send 0x55 at 97% and 103% of nominal bit period → `data`=0x55 in both cases.

Source files
------------

// File: rtl/uart_byte_receiver_if.sv
// rtl/uart_byte_receiver_if.sv - serial line and byte-output bundle for uart_byte_receiver
interface uart_byte_receiver_if;
  logic       rx;
  logic [7:0] data;
  logic       data_valid;
  logic       framing_error;
  logic       busy;

  modport master (
    output rx,
    input  data,
    input  data_valid,
    input  framing_error,
    input  busy
  );

  modport slave (
    input  rx,
    output data,
    output data_valid,
    output framing_error,
    output busy
  );
endinterface

// File: rtl/uart_byte_receiver.sv
// rtl/uart_byte_receiver.sv - 8N1 UART receiver, 16x oversampling with mid-bit sampling
module uart_byte_receiver #(
  parameter int unsigned baudrate  = 32'd9600,
  parameter int unsigned frequency = 32'd100000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  uart_byte_receiver_if.slave  port
);

  localparam int unsigned DIV      = frequency / (baudrate * 32'd16);
  localparam logic [31:0] DIV_LAST = 32'(DIV - 32'd1);

  if (DIV < 2) begin : g_div_check
    $error("uart_byte_receiver: oversample divisor must be at least 2");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        rx_meta_q, rx_sync_q;
  logic [31:0] div_q, div_d;
  logic [3:0]  s_q, s_d;
  logic [2:0]  n_q, n_d;
  logic [7:0]  shift_q, shift_d;
  logic        armed_q, armed_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        ferr_q, ferr_d;
  logic        rxs;
  logic        stick;
  logic        div_clr;

  // Synchronizer flops reset high so a reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= port.rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  assign rxs   = rx_sync_q;
  assign stick = (div_q == DIV_LAST);

  always_comb begin
    div_d = div_q + 32'd1;
    if (div_clr || stick) begin
      div_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      s_q     <= '0;
      n_q     <= '0;
      shift_q <= '0;
      armed_q <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      s_q     <= s_d;
      n_q     <= n_d;
      shift_q <= shift_d;
      armed_q <= armed_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    shift_d = shift_q;
    armed_d = armed_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    div_clr = 1'b0;
    case (state_q)
      IDLE: begin
        if (rxs) begin
          armed_d = 1'b1;
        end
        // Clearing the divider here puts every later tick in phase with the start edge.
        if (armed_q && !rxs) begin
          state_d = START;
          s_d     = '0;
          div_clr = 1'b1;
        end
      end
      START: begin
        if (stick) begin
          s_d = s_q + 4'd1;
          if (s_q == 4'd7) begin
            if (!rxs) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      DATA: begin
        if (stick) begin
          s_d = s_q + 4'd1;
          if (s_q == 4'd15) begin
            shift_d = {rxs, shift_q[7:1]};
            if (n_q == 3'd7) begin
              state_d = STOP;
            end else begin
              n_d = n_q + 3'd1;
            end
          end
        end
      end
      STOP: begin
        if (stick) begin
          s_d = s_q + 4'd1;
          if (s_q == 4'd15) begin
            state_d = IDLE;
            if (rxs) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              // Stay disarmed until the line returns high so a break reports only once.
              ferr_d  = 1'b1;
              armed_d = 1'b0;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign port.data          = data_q;
  assign port.data_valid    = valid_q;
  assign port.framing_error = ferr_q;
  assign port.busy          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_byte_receiver.sv
// tb/tb_uart_byte_receiver.sv - self-checking bench for uart_byte_receiver
module tb_uart_byte_receiver;

  typedef struct {
    logic [7:0] b;
    logic       stop;
    int         bclk;
    int         gap;
    int         exp_v;
    int         exp_f;
    logic [7:0] exp_d;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  int   n_vld = 0;
  int   n_fe  = 0;
  int   cyc   = 0;
  int   vld_cyc = 0;

  uart_byte_receiver_if bus();

  uart_byte_receiver #(
    .baudrate  (32'd100000),
    .frequency (32'd3200000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .port  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.data_valid || bus.framing_error) begin
      tests++;
      if (bus.data_valid && bus.framing_error) begin
        fails++;
        $display("FAIL exclusive_pulse: data_valid=1 framing_error=1, required at most one high");
      end
      if (bus.data_valid) begin
        n_vld++;
        vld_cyc = cyc;
      end
      if (bus.framing_error) n_fe++;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int bclk);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      bus.rx = bits[i];
      tick(bclk);
    end
  endtask

  task automatic run_frame(input string name, input logic [7:0] b, input logic stop,
                           input int bclk, input int gap, input int exp_v,
                           input int exp_f, input logic [7:0] exp_d);
    int v0, f0;
    v0 = n_vld;
    f0 = n_fe;
    send_frame(b, stop, bclk);
    if (gap > 0) begin
      bus.rx = 1'b1;
      tick(gap);
    end
    check({name, "_valid_pulses"}, n_vld - v0, exp_v);
    check({name, "_ferr_pulses"}, n_fe - f0, exp_f);
    check({name, "_data"}, int'(bus.data), int'(exp_d));
  endtask

  initial begin
    vec_t vecs[7];
    int   c0, v0, f0, waited;
    logic [7:0] model_data;
    logic [7:0] rb;
    logic       rstop;
    int         rbclk, rgap;
    logic [9:0] rbits;

    vecs[0] = '{8'hA5, 1'b1, 32, 40, 1, 0, 8'hA5};
    vecs[1] = '{8'h00, 1'b1, 32,  0, 1, 0, 8'h00};
    vecs[2] = '{8'hFF, 1'b1, 32, 40, 1, 0, 8'hFF};
    vecs[3] = '{8'h3C, 1'b0, 32, 40, 0, 1, 8'hFF};
    vecs[4] = '{8'h81, 1'b1, 32, 40, 1, 0, 8'h81};
    vecs[5] = '{8'h55, 1'b1, 31, 40, 1, 0, 8'h55};
    vecs[6] = '{8'h55, 1'b1, 33, 40, 1, 0, 8'h55};

    bus.rx = 1'b1;
    #2;
    check("reset_data", int'(bus.data), 0);
    check("reset_valid", int'(bus.data_valid), 0);
    check("reset_ferr", int'(bus.framing_error), 0);
    check("reset_busy", int'(bus.busy), 0);
    tick(3);
    rst_n = 1'b1;
    tick(40);

    for (int i = 0; i < 7; i++) begin
      c0 = cyc;
      run_frame($sformatf("vec%0d", i), vecs[i].b, vecs[i].stop, vecs[i].bclk,
                vecs[i].gap, vecs[i].exp_v, vecs[i].exp_f, vecs[i].exp_d);
      if (i == 0) begin
        check("vec0_latency_in_window",
              int'((vld_cyc - c0) >= 304 && (vld_cyc - c0) <= 310), 1);
      end
    end

    // Short low glitch must be rejected at the start-bit centre.
    v0 = n_vld;
    f0 = n_fe;
    bus.rx = 1'b0;
    tick(6);
    check("glitch_busy_high", int'(bus.busy), 1);
    tick(2);
    bus.rx = 1'b1;
    waited = 0;
    while (bus.busy && waited < 40) begin
      tick(1);
      waited++;
    end
    check("glitch_busy_clear", int'(bus.busy), 0);
    tick(40);
    check("glitch_no_valid", n_vld - v0, 0);
    check("glitch_no_ferr", n_fe - f0, 0);

    // Bad stop bit followed by a long break, then a good frame.
    v0 = n_vld;
    f0 = n_fe;
    send_frame(8'h3C, 1'b0, 32);
    tick(2000);
    check("break_one_ferr", n_fe - f0, 1);
    check("break_no_valid", n_vld - v0, 0);
    check("break_data_kept", int'(bus.data), 8'h55);
    bus.rx = 1'b1;
    tick(64);
    run_frame("after_break", 8'h81, 1'b1, 32, 40, 1, 0, 8'h81);

    // Reset pulse in the middle of data bit 4.
    v0 = n_vld;
    f0 = n_fe;
    rbits = {1'b1, 8'hF0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      bus.rx = rbits[i];
      tick(32);
    end
    bus.rx = rbits[5];
    tick(16);
    rst_n = 1'b0;
    #1;
    check("midreset_data", int'(bus.data), 0);
    check("midreset_valid", int'(bus.data_valid), 0);
    check("midreset_ferr", int'(bus.framing_error), 0);
    check("midreset_busy", int'(bus.busy), 0);
    tick(1);
    rst_n = 1'b1;
    tick(16);
    for (int i = 6; i < 10; i++) begin
      bus.rx = rbits[i];
      tick(32);
    end
    tick(40);
    check("midreset_no_valid", n_vld - v0, 0);
    check("midreset_no_ferr", n_fe - f0, 0);
    check("midreset_data_cleared", int'(bus.data), 0);
    run_frame("after_reset", 8'h5A, 1'b1, 32, 40, 1, 0, 8'h5A);

    // Random frames against a frame-level reference: good stop delivers the byte, bad stop keeps the old one.
    model_data = 8'h5A;
    for (int i = 0; i < 16; i++) begin
      rb    = 8'($urandom_range(0, 255));
      rstop = ($urandom_range(0, 3) != 0);
      rbclk = 31 + int'($urandom_range(0, 2));
      rgap  = 8 + int'($urandom_range(0, 40));
      if (rstop) model_data = rb;
      run_frame($sformatf("rand%0d", i), rb, rstop, rbclk, rgap,
                rstop ? 1 : 0, rstop ? 0 : 1, model_data);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
